// File: rtl/vproc_pkg.sv
// Shared types for the vector processor pipeline receiver.
// Holds the per-entry lifecycle encoding of the receiver's ring buffer.
package vproc_pkg;

    typedef enum logic [1:0] {
        PIPE_RX_FREE,
        PIPE_RX_QUEUED,
        PIPE_RX_ISSUED,
        PIPE_RX_DONE
    } vproc_pipe_rx_state_e;

endpackage

// File: rtl/vproc_pipe_receiver.sv
// Pipeline-side end of the dispatch handshake.
// Buffers dispatched instructions in a DEPTH-entry ring, issues them in order
// to the execution unit with a tag, and pulses the pending-vreg clear mask
// when the unit reports completion.
// Optional feature macro: VPROC_PIPE_RX_BYPASS_EN (same-cycle issue into an
// empty ring).
module vproc_pipe_receiver
    import vproc_pkg::*;
#(
    parameter int  DEPTH          = 4,
    parameter int  MAX_VADDR_W    = 5,
    parameter type DECODER_DATA_T = logic,
    parameter bit  DONT_CARE_ZERO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         sync_rst_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  DECODER_DATA_T                disp_data_i,
    input  logic [(1<<MAX_VADDR_W)-1:0]  disp_vreg_wr_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output DECODER_DATA_T                issue_data_o,
    output logic [$clog2(DEPTH)-1:0]     issue_tag_o,
    input  logic                         done_valid_i,
    input  logic [$clog2(DEPTH)-1:0]     done_tag_i,
    output logic [(1<<MAX_VADDR_W)-1:0]  pend_vreg_wr_clr_o,
    output logic                         empty_o
);

    localparam int TAG_W     = $clog2(DEPTH);
    localparam int VADDR_CNT = 1 << MAX_VADDR_W;

    vproc_pipe_rx_state_e   state_q [DEPTH];
    DECODER_DATA_T          data_q  [DEPTH];
    logic [VADDR_CNT-1:0]   map_q   [DEPTH];

    logic [TAG_W-1:0]       alloc_ptr;
    logic [TAG_W-1:0]       issue_ptr;
    logic [TAG_W-1:0]       retire_ptr;
    logic [VADDR_CNT-1:0]   clr_q;

    logic                   ring_empty;
    logic                   bypass;
    logic                   accept;
    logic                   issue_fire;
    logic                   done_ok;
    logic                   retire;

    // The ring is empty only when every entry is FREE; pointer equality alone cannot tell full from empty.
    always_comb begin
        ring_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != PIPE_RX_FREE) begin
                ring_empty = 1'b0;
            end
        end
    end

`ifdef VPROC_PIPE_RX_BYPASS_EN
    assign bypass = ring_empty & disp_valid_i;
`else
    assign bypass = 1'b0;
`endif

    // Handshake decode: accept, issue offer, completion validity and in-order retire.
    always_comb begin
        disp_ready_o  = (state_q[alloc_ptr] == PIPE_RX_FREE);
        accept        = disp_valid_i & disp_ready_o;
`ifdef VPROC_PIPE_RX_BYPASS_EN
        issue_valid_o = bypass | (state_q[issue_ptr] == PIPE_RX_QUEUED);
        issue_data_o  = bypass ? disp_data_i : data_q[issue_ptr];
        issue_tag_o   = bypass ? alloc_ptr : issue_ptr;
`else
        issue_valid_o = (state_q[issue_ptr] == PIPE_RX_QUEUED);
        issue_data_o  = data_q[issue_ptr];
        issue_tag_o   = issue_ptr;
`endif
        if (DONT_CARE_ZERO && !issue_valid_o) begin
            issue_data_o = '0;
            issue_tag_o  = '0;
        end
        issue_fire    = issue_valid_o & issue_ready_i;
        done_ok       = done_valid_i & (state_q[done_tag_i] == PIPE_RX_ISSUED);
        retire        = (state_q[retire_ptr] == PIPE_RX_DONE);
    end

    // Entry lifecycle and pointers; the four transitions always touch distinct entries.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= PIPE_RX_FREE;
            end
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            clr_q      <= '0;
        end else begin
            clr_q <= done_ok ? map_q[done_tag_i] : '0;
            if (retire) begin
                state_q[retire_ptr] <= PIPE_RX_FREE;
                retire_ptr          <= retire_ptr + 1'b1;
            end
            if (done_ok) begin
                state_q[done_tag_i] <= PIPE_RX_DONE;
            end
            if (issue_fire && !bypass) begin
                state_q[issue_ptr] <= PIPE_RX_ISSUED;
                issue_ptr          <= issue_ptr + 1'b1;
            end
            if (accept) begin
                state_q[alloc_ptr] <= (bypass && issue_fire) ? PIPE_RX_ISSUED : PIPE_RX_QUEUED;
                alloc_ptr          <= alloc_ptr + 1'b1;
                if (bypass && issue_fire) begin
                    issue_ptr <= issue_ptr + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset; it is only read while its entry is occupied.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            data_q[alloc_ptr] <= disp_data_i;
            map_q[alloc_ptr]  <= disp_vreg_wr_i;
        end
    end

    assign pend_vreg_wr_clr_o = clr_q;
    assign empty_o            = ring_empty;

    // A completion for an entry that is not in flight is dropped; flag it for the unit's designer.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i && done_valid_i) begin
            assert (state_q[done_tag_i] == PIPE_RX_ISSUED)
            else $warning("done_tag %0d is not in ISSUED state; completion ignored", done_tag_i);
        end
    end

    // Completing the entry being issued in the same cycle is a protocol violation by the unit.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            assert (!(done_valid_i && issue_fire && (done_tag_i == issue_tag_o)))
            else $error("done and issue of tag %0d in the same cycle", done_tag_i);
        end
    end

endmodule
